// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder built from STAGES carry-chained chunks with valid/ready flow control.
// Optional feature: define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW  = WIDTH / STAGES;
    localparam int TOP = STAGES - 1;

    logic adv;

    // One global enable: the whole pipe either shifts together or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed; chunk k always sits at the bottom.
        localparam int RW = (STAGES - k) * CW;

        logic [RW-1:0]       a_in;
        logic [RW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [CW:0]         chunk;
        logic                v_q;
        logic                c_q;
        logic [(k+1)*CW-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_in = in1;
            assign b_in = in2;
            assign c_in = cin;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= chunk[CW];
            end
        end

        // Finished low chunks ride along with the transaction so all chunks emerge together.
        if (k == 0) begin : g_sum
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (adv) begin
                    s_q <= chunk[CW-1:0];
                end
            end
        end else begin : g_sum
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (adv) begin
                    s_q <= {chunk[CW-1:0], g_stage[k-1].s_q};
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:CW];
                    b_q <= b_in[RW-1:CW];
                end
            end
        end
    end

    assign sum       = g_stage[TOP].s_q;
    assign cout      = g_stage[TOP].c_q;
    assign out_valid = g_stage[TOP].v_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[TOP].a_in[CW-1] ^ g_stage[TOP].b_in[CW-1]
                   ^ g_stage[TOP].chunk[CW-1] ^ g_stage[TOP].chunk[CW];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: an 8-bit/2-stage and a 16-bit/4-stage instance,
// each with a scoreboard filled on input transfers and drained on output transfers.
module tb_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  in1_8, in2_8, sum8;
    logic        cin8, in_valid8, in_ready8, cout8, out_valid8, out_ready8;
    logic [15:0] in1_16, in2_16, sum16;
    logic        cin16, in_valid16, in_ready16, cout16, out_valid16, out_ready16;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf8, ovf16;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int delivered8 = 0;
    int delivered16 = 0;

    // Scoreboard entries are {ovf, cout, sum}.
    logic [9:0]  sb8[$];
    logic [17:0] sb16[$];
    logic [9:0]  exp8, pop8;
    logic [17:0] exp16, pop16;
    logic [8:0]  s9;
    logic [16:0] s17;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in1(in1_8), .in2(in2_8), .cin(cin8),
        .in_valid(in_valid8), .in_ready(in_ready8), .sum(sum8), .cout(cout8),
        .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in1(in1_16), .in2(in2_16), .cin(cin16),
        .in_valid(in_valid16), .in_ready(in_ready16), .sum(sum16), .cout(cout16),
        .out_valid(out_valid16), .out_ready(out_ready16)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    // Output transfers pop and compare, input transfers push the reference result.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb8.delete();
        end else begin
            if (out_valid8 && out_ready8) begin
                delivered8++;
                tests_run++;
                if (sb8.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL dut8_unexpected: got sum=%h cout=%b required no output", sum8, cout8);
                end else begin
                    pop8 = sb8.pop_front();
                    if ({cout8, sum8} !== pop8[8:0]) begin
                        tests_failed++;
                        $display("[TB] FAIL dut8_result: got %h required %h", {cout8, sum8}, pop8[8:0]);
                    end
`ifdef PIPE_ADDER_OVF_EN
                    tests_run++;
                    if (ovf8 !== pop8[9]) begin
                        tests_failed++;
                        $display("[TB] FAIL dut8_ovf: got %b required %b", ovf8, pop8[9]);
                    end
`endif
                end
            end
            if (in_valid8 && in_ready8) begin
                s9 = {1'b0, in1_8} + {1'b0, in2_8} + {8'd0, cin8};
                exp8 = {(in1_8[7] == in2_8[7]) && (s9[7] != in1_8[7]), s9};
                sb8.push_back(exp8);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb16.delete();
        end else begin
            if (out_valid16 && out_ready16) begin
                delivered16++;
                tests_run++;
                if (sb16.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL dut16_unexpected: got sum=%h cout=%b required no output", sum16, cout16);
                end else begin
                    pop16 = sb16.pop_front();
                    if ({cout16, sum16} !== pop16[16:0]) begin
                        tests_failed++;
                        $display("[TB] FAIL dut16_result: got %h required %h", {cout16, sum16}, pop16[16:0]);
                    end
`ifdef PIPE_ADDER_OVF_EN
                    tests_run++;
                    if (ovf16 !== pop16[17]) begin
                        tests_failed++;
                        $display("[TB] FAIL dut16_ovf: got %b required %b", ovf16, pop16[17]);
                    end
`endif
                end
            end
            if (in_valid16 && in_ready16) begin
                s17 = {1'b0, in1_16} + {1'b0, in2_16} + {16'd0, cin16};
                exp16 = {(in1_16[15] == in2_16[15]) && (s17[15] != in1_16[15]), s17};
                sb16.push_back(exp16);
            end
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        in1_8 = a;
        in2_8 = b;
        cin8 = c;
        in_valid8 = 1'b1;
        tick();
    endtask

    task test_reset;
        rst_n = 1'b0;
        in1_8 = '0; in2_8 = '0; cin8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        in1_16 = '0; in2_16 = '0; cin16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({out_valid8, cout8, sum8} !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut8: got %h required 000", {out_valid8, cout8, sum8});
        end
        tests_run++;
        if ({out_valid16, cout16, sum16} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut16: got %h required 00000", {out_valid16, cout16, sum16});
        end
`ifdef PIPE_ADDER_OVF_EN
        tests_run++;
        if ({ovf8, ovf16} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_ovf: got %b required 00", {ovf8, ovf16});
        end
`endif
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({in_ready8, in_ready16} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b required 11", {in_ready8, in_ready16});
        end
    endtask

    task test_basic;
        int n;
        applyStimulus(8'h01, 8'h02, 1'b0);
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 2 || out_valid8 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: got %0d cycles required 2", n);
        end
        tick();
        tests_run++;
        if (out_valid8 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_single_pulse: got out_valid=%b required 0", out_valid8);
        end
    endtask

    task test_carry;
        applyStimulus(8'h0F, 8'h01, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        applyStimulus(8'h0F, 8'h0F, 1'b1);
        in_valid8 = 1'b0;
        for (int i = 0; i < 20 && sb8.size() != 0; i++) tick();
        tests_run++;
        if (sb8.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL carry_drain: got %0d pending required 0", sb8.size());
        end
    endtask

    task test_back_to_back;
        int idx, start;
        logic [8:0] snap;
        start = delivered8;
        idx = 1;
        for (int c = 0; c < 40 && idx <= 4; c++) begin
            in_valid8 = 1'b1;
            in1_8 = 8'(idx);
            in2_8 = 8'(idx);
            cin8 = 1'b0;
            out_ready8 = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                tests_run++;
                if (in_ready8 !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_in_ready: got %b required 0 (cycle %0d)", in_ready8, c);
                end
                if (c == 2) begin
                    snap = {cout8, sum8};
                end else begin
                    tests_run++;
                    if ({cout8, sum8} !== snap || out_valid8 !== 1'b1) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_hold: got %h/%b required %h/1", {cout8, sum8}, out_valid8, snap);
                    end
                end
            end
            if (in_ready8) idx++;
            tick();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 20 && sb8.size() != 0; i++) tick();
        repeat (3) tick();
        tests_run++;
        if (delivered8 - start != 4 || sb8.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d delivered required 4", delivered8 - start);
        end
    endtask

    task test_reset_midstream;
        int start, n;
        logic seen;
        applyStimulus(8'h11, 8'h22, 1'b0);
        applyStimulus(8'h33, 8'h44, 1'b0);
        tests_run++;
        if (out_valid8 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_in_flight: got out_valid=%b required 1", out_valid8);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({out_valid8, cout8, sum8} !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_clear: got %h required 000", {out_valid8, cout8, sum8});
        end
        rst_n = 1'b1;
        out_ready8 = 1'b1;
        start = delivered8;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid8) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || delivered8 != start) begin
            tests_failed++;
            $display("[TB] FAIL midreset_flushed: got out_valid seen=%b required 0", seen);
        end
        applyStimulus(8'h05, 8'h06, 1'b0);
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 2) begin
            tests_failed++;
            $display("[TB] FAIL midreset_latency: got %0d cycles required 2", n);
        end
        tick();
    endtask

    task test_random_flow;
        logic hold, stalled;
        logic [9:0] snap;
        hold = 1'b0;
        stalled = 1'b0;
        snap = '0;
        for (int c = 0; c < 80; c++) begin
            if (!hold) begin
                in_valid8 = ($urandom_range(0, 3) != 0);
                in1_8 = 8'($urandom);
                in2_8 = 8'($urandom);
                cin8 = 1'($urandom);
            end
            out_ready8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stalled) begin
                tests_run++;
                if ({out_valid8, cout8, sum8} !== snap) begin
                    tests_failed++;
                    $display("[TB] FAIL random_hold: got %h required %h", {out_valid8, cout8, sum8}, snap);
                end
            end
            stalled = out_valid8 && !out_ready8;
            snap = {out_valid8, cout8, sum8};
            hold = in_valid8 && !in_ready8;
            tick();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 20 && sb8.size() != 0; i++) tick();
        tests_run++;
        if (sb8.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL random_drain: got %0d pending required 0", sb8.size());
        end
    endtask

    task test_wide;
        int n;
        in1_16 = 16'hFFFF;
        in2_16 = 16'h0000;
        cin16 = 1'b1;
        in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        n = 1;
        while (!out_valid16 && n < 12) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 4 || {cout16, sum16} !== 17'h10000) begin
            tests_failed++;
            $display("[TB] FAIL wide_latency: got %0d cycles %h required 4 cycles 10000", n, {cout16, sum16});
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            in1_16 = 16'($urandom);
            in2_16 = (i < 2) ? ~in1_16 : 16'($urandom);
            cin16 = (i == 1) ? 1'b1 : 1'($urandom);
            in_valid16 = 1'b1;
            tick();
        end
        in_valid16 = 1'b0;
        for (int i = 0; i < 20 && sb16.size() != 0; i++) tick();
        tests_run++;
        if (sb16.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL wide_drain: got %0d pending required 0", sb16.size());
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task test_ovf;
        applyStimulus(8'h7F, 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        applyStimulus(8'h01, 8'h01, 1'b0);
        in_valid8 = 1'b0;
        for (int i = 0; i < 20 && sb8.size() != 0; i++) tick();
        tests_run++;
        if (sb8.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_drain: got %0d pending required 0", sb8.size());
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_midstream();
        test_random_flow();
        test_wide();
`ifdef PIPE_ADDER_OVF_EN
        test_ovf();
`endif
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's combinational N-bit full adder.
- Splits a WIDTH-bit add into STAGES equal carry-chained chunks, one register stage per chunk, so wide adds close timing at high clock rates.
- Valid/ready handshake on both sides; sits between datapath producers and consumers that tolerate fixed latency.

Parameters:
- WIDTH, 8, operand/sum width in bits.
- STAGES, 2, pipeline stages = carry chunks; WIDTH % STAGES must be 0; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry in.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- sum  output  WIDTH  in1+in2+cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Chunk width CW = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*CW +: CW] of the skewed operands plus the registered carry from stage k-1. Stage 0 uses cin.
- Skew: upper operand chunks are delayed k cycles before stage k. Deskew: lower sum chunks are delayed so that all chunks of one transaction emerge together.
- Arithmetic is unsigned modulo 2^WIDTH. cout = carry out of the top chunk. The result is bit-identical to the combinational adder.
- Global advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- While adv=1, every stage register, including its valid bit, shifts one step. Stage 0 valid loads in_valid.
- While adv=0, all stage registers hold; sum, cout and out_valid are stable until accepted.
- Latency: a result appears on out_valid exactly STAGES cycles after its input transfer when no stall occurs. Each stall cycle adds one.
- Throughput: one transaction per cycle while out_ready=1.
- Bubbles are not collapsed; an empty slot travels the pipe like data.
- Ordering is strictly FIFO.
- in_valid with in_ready=0: the operands are not captured, and the producer must hold them.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Reset (rst_n=0 at a clock edge): all valid bits, sum, cout and every data/carry register clear to 0. in_ready reads 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight transactions; no partial result is ever presented.
- in1, in2 and cin are ignored when in_valid=0. The outputs sum and cout are don't-care when out_valid=0, but reset to 0.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow flag. It is computed in the top stage as carry_into_msb XOR carry_out_of_msb and is pipelined aligned with sum. Reset value 0; it holds under stall exactly like sum.
- Not defined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: in1=01, in2=02, cin=0, one cycle valid -> after 2 cycles out_valid=1, sum=03, cout=0, then out_valid=0.
- Carry across chunk boundary: in1=0F, in2=01, cin=0 -> sum=10, cout=0. Then in1=FF, in2=01 -> sum=00, cout=1. Then in1=0F, in2=0F, cin=1 -> sum=1F.
- Back-to-back stream of 4 transactions (i+i, i=1..4), out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, results 02,04,06,08 delivered in order with none lost or duplicated.
- Reset mid-stream: 2 transactions in flight, rst_n=0 one cycle -> out_valid=0, sum=00, cout=0 next cycle; the flushed results never appear; the next input returns after 2 cycles.
- WIDTH=16, STAGES=4: in1=FFFF, in2=0000, cin=1 -> sum=0000, cout=1 after exactly 4 cycles.
- With PIPE_ADDER_OVF_EN, WIDTH=8: 7F+01 -> sum=80, ovf=1. 80+80 -> sum=00, cout=1, ovf=1. 01+01 -> ovf=0.
